// File: rtl/nibble_addsub_seq_if.sv
// Operand/result bundle for nibble_addsub_seq.
// master drives the request side; slave is the sequencer.
interface nibble_addsub_seq_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_addsub_seq.sv
// Wide add/sub built from one 4-bit slice, one nibble per clock, carry chained in a register.
// Optional macro ADDSUB_SAT_EN: saturate the result on signed overflow at completion.
module nibble_addsub_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input logic               clk,
  input logic               rst,
  nibble_addsub_seq_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sub;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_result;
  logic          r_busy;
  logic          r_done;
  logic          r_cout;
  logic          r_ovf;
  logic          r_zero;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [4:0]    w_sum;
  logic [3:0]    w_low;
  logic          w_ovf;
  logic          w_last;
  logic [W-1:0]  w_res_full;
  logic [W-1:0]  w_res_final;

  always_comb begin
    w_a_nib    = r_a[{r_idx, 2'b00} +: 4];
    w_b_nib    = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_sub}};
    w_sum      = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    // Carry into bit 3 of the slice; only meaningful on the top nibble.
    w_low      = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
    w_ovf      = w_low[3] ^ w_sum[4];
    w_last     = (r_idx == IW'(NIBBLES - 1));
    w_res_full = r_result;
    w_res_full[{r_idx, 2'b00} +: 4] = w_sum[3:0];
`ifdef ADDSUB_SAT_EN
    if (w_ovf)
      w_res_final = w_res_full[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    else
      w_res_final = w_res_full;
`else
    w_res_final = w_res_full;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sub   <= bus.op_sub;
            r_idx   <= '0;
            r_carry <= bus.op_sub;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_carry <= w_sum[4];
          if (w_last) begin
            r_idx    <= '0;
            r_result <= w_res_final;
            r_cout   <= w_sum[4];
            r_ovf    <= w_ovf;
            r_zero   <= (w_res_final == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx    <= r_idx + IW'(1);
            r_result <= w_res_full;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;
endmodule
